round_shift_pipe: RTL and testbench
===================================

ROUND_SHIFT_PIPE -- requirements
Module: round_shift_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 64, datapath width in bits; legal values are multiples of 64.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous active-high reset.
REQ-004 SHALL have port in_valid  input  1  operand beat valid.
REQ-005 SHALL have port in_ready  output  1  block accepts a beat this cycle.
REQ-006 SHALL have port vxrm  input  2  rounding mode: 00 rnu, 01 rne, 10 rdn, 11 rod.
REQ-007 SHALL have port sew  input  2  result lane width: 00=8, 01=16, 10=32, 11=64.
REQ-008 SHALL have port is_signed  input  1  1 = arithmetic shift and signed clip, 0 = logical shift and unsigned clip.
REQ-009 SHALL have port narrow  input  1  1 = source lanes are 2*SEW and results are clipped to SEW.
REQ-010 SHALL have port vs2  input  DATA_W  packed source lanes.
REQ-011 SHALL have port shamt  input  DATA_W  packed per-lane shift amounts, lane-aligned with the source lanes; only the low log2(source lane width) bits are used.
REQ-012 SHALL have port out_valid  output  1  result beat valid.
REQ-013 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-014 SHALL have port out  output  DATA_W  packed result lanes.
REQ-015 SHALL have port vxsat  output  1  high with out_valid when any lane of the beat clipped.

Function
REQ-016 SHALL, per lane with source value v and shift d, produce (v >> d) + r, where >> is arithmetic when is_signed=1 and logical otherwise.
REQ-017 SHALL compute r as: rnu v[d-1]; rne v[d-1] & (v[d-2:0]!=0 | v[d]); rdn 0; rod !v[d] & (v[d-1:0]!=0).
REQ-018 SHALL force r=0 when d=0; for d=1 the v[d-2:0] term SHALL be 0.
REQ-019 SHALL evaluate the addition at source lane width + 1 bits, then truncate (narrow=0) or clip (narrow=1) to SEW.
REQ-020 SHALL, with narrow=1, place results in the low DATA_W/2 bits of out, packed at SEW, and drive the upper half to 0.
REQ-021 SHALL ignore narrow when sew=11 and treat the beat as non-narrowing.
REQ-022 SHALL be a two-stage pipeline: S1 registers shift+round, S2 registers clip, out and vxsat; latency is 2 cycles from in_valid&in_ready to out_valid when not stalled.
REQ-023 SHALL advance S2 when !out_valid | out_ready, and S1 when !S1_valid | S2 advances; in_ready SHALL equal the S1 advance condition, giving 1 beat/cycle throughput.
REQ-024 SHALL hold out, vxsat and out_valid stable while out_valid & !out_ready.
REQ-025 SHALL capture vxrm, sew, is_signed and narrow with the beat, so that mode changes between beats do not affect beats already in flight.
REQ-026 SHALL emit beats in acceptance order with no loss or duplication under any in_valid/out_ready pattern.

Reset
REQ-027 SHALL, while rst=1, clear both stage-valid flags, drive out=0, vxsat=0 and out_valid=0, and drive in_ready=1 in the cycle after reset.
REQ-028 SHALL discard beats in flight when rst asserts mid-operation; no result is emitted for them.

Configuration
REQ-029 SHALL, when ROUND_SHIFT_NCLIP_EN is defined, implement narrow clipping: signed range [-2^(SEW-1), 2^(SEW-1)-1], unsigned range [0, 2^SEW-1], with vxsat set when any lane saturates.
REQ-030 SHALL, when ROUND_SHIFT_NCLIP_EN is undefined, treat the narrow input as 0, tie vxsat to 0, and omit the clip logic.

Verification
REQ-031 SHALL cover: sew=00, is_signed=1, lane 0x87, d=2 -> rnu 0xE2, rne 0xE2, rdn 0xE1, rod 0xE1.
REQ-032 SHALL cover: sew=00, is_signed=0, lane 0x02, d=2 -> rnu 0x01, rne 0x00, rdn 0x00, rod 0x01; lane 0xFF, d=0 -> 0xFF in all modes.
REQ-033 SHALL cover, with ROUND_SHIFT_NCLIP_EN defined: sew=00, narrow=1, is_signed=1, 16-bit lane 0x7FFF, d=4, rnu -> out lane 0x7F, vxsat=1, upper half of out = 0.
REQ-034 SHALL cover: out_ready=0 with 3 beats offered back-to-back -> in_ready drops after 2 beats are held; releasing out_ready delivers all 3 beats in order, one per cycle.
REQ-035 SHALL cover: sew=11, DATA_W=128, two 64-bit lanes with distinct d and vxrm=01 -> each lane matches the reference model, and the beat appears 2 cycles after acceptance.
REQ-036 SHALL cover: rst=1 asserted with 2 beats in flight -> out_valid=0 the next cycle, out=0, and no stale beat appears afterwards.

Source files
------------

// File: rtl/round_shift_pipe.sv
// round_shift_pipe: two-stage per-lane rounding right shift; narrowing clip enabled by ROUND_SHIFT_NCLIP_EN
module round_shift_pipe #(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        vxrm,
    input  logic [1:0]        sew,
    input  logic              is_signed,
    input  logic              narrow,
    input  logic [DATA_W-1:0] vs2,
    input  logic [DATA_W-1:0] shamt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out,
    output logic              vxsat
);
    logic              s1_v_q, s1_v_d;
    logic [DATA_W-1:0] s1_res_q, s1_res_d;
    logic              out_v_q, out_v_d;
    logic [DATA_W-1:0] out_q, out_d;
    logic              vxsat_q, vxsat_d;
    logic              nr, adv2, sat2;
    logic [DATA_W-1:0] res2;
    logic [DATA_W-1:0] rw [4];

    // Shift and round one lane in a 64-bit extended domain; for d>=1 the result always fits the source width
    function automatic logic [63:0] rnd(input logic [63:0] raw, input int w, input logic [5:0] d,
                                        input logic [1:0] m, input logic sg);
        logic [63:0] v, sa, sh;
        logic signed [63:0] a;
        logic half, lo_nz, all_nz, r;
        v = sg & raw[6'(w - 1)] ? raw | ~((64'd1 << w) - 64'd1) : raw;
        a = $signed(v);
        sa = a >>> d;
        sh = sg ? sa : v >> d;
        half = d != 6'd0 && v[d - 6'd1];
        lo_nz = d > 6'd1 && (v & ((64'd1 << (d - 6'd1)) - 64'd1)) != 64'd0;
        all_nz = (v & ((64'd1 << d) - 64'd1)) != 64'd0;
        r = m == 2'b00 ? half : m == 2'b01 ? half & (lo_nz | v[d]) : m == 2'b10 ? 1'b0 : ~v[d] & all_nz;
        return sh + {63'd0, r};
    endfunction

    // One rounded candidate per source lane width (8/16/32/64); the active one is chosen by sew and narrow
    for (genvar w = 0; w < 4; w++) begin : g_w
        localparam int W = 8 << w;
        for (genvar j = 0; j < DATA_W / W; j++) begin : g_l
            assign rw[w][j*W +: W] = W'(rnd(64'(vs2[j*W +: W]), W, 6'(shamt[j*W +: $clog2(W)]), vxrm, is_signed));
        end
    end

`ifdef ROUND_SHIFT_NCLIP_EN
    localparam int HW = DATA_W / 2;
    logic [1:0]    s1_sew_q, s1_sew_d;
    logic          s1_sg_q, s1_sg_d, s1_nr_q, s1_nr_d;
    logic [HW-1:0] cw [3];
    logic [HW-1:0] cs [3];
    logic [HW-1:0] cw_sel, cs_sel;

    assign nr = narrow & (sew != 2'b11);

    // Clip each 2*SEW lane to SEW; cs carries a per-lane saturation flag smeared over the lane
    for (genvar k = 0; k < 3; k++) begin : g_c
        localparam int S = 8 << k;
        for (genvar j = 0; j < HW / S; j++) begin : g_l
            logic [2*S-1:0] x;
            logic           ovf;
            assign x = s1_res_q[j*2*S +: 2*S];
            assign ovf = s1_sg_q ? ~(&x[2*S-1:S-1] | ~|x[2*S-1:S-1]) : |x[2*S-1:S];
            assign cw[k][j*S +: S] = !ovf ? x[S-1:0] : s1_sg_q ? {x[2*S-1], {(S-1){~x[2*S-1]}}} : {S{1'b1}};
            assign cs[k][j*S +: S] = {S{ovf}};
        end
    end

    assign cw_sel = s1_sew_q[1] ? cw[2] : s1_sew_q[0] ? cw[1] : cw[0];
    assign cs_sel = s1_sew_q[1] ? cs[2] : s1_sew_q[0] ? cs[1] : cs[0];
    assign res2 = s1_nr_q ? {{HW{1'b0}}, cw_sel} : s1_res_q;
    assign sat2 = s1_nr_q & |cs_sel;

    // Capture the clip controls with each accepted beat
    always_comb begin
        s1_sew_d = in_ready & in_valid ? sew : s1_sew_q;
        s1_sg_d  = in_ready & in_valid ? is_signed : s1_sg_q;
        s1_nr_d  = in_ready & in_valid ? nr : s1_nr_q;
    end

    // Clip control registers travelling alongside the S1 data
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_sew_q <= 2'b00;
            s1_sg_q  <= 1'b0;
            s1_nr_q  <= 1'b0;
        end else begin
            s1_sew_q <= s1_sew_d;
            s1_sg_q  <= s1_sg_d;
            s1_nr_q  <= s1_nr_d;
        end
    end
`else
    logic unused_narrow;
    assign unused_narrow = narrow;
    assign nr = 1'b0;
    assign res2 = s1_res_q;
    assign sat2 = 1'b0;
`endif

    assign adv2      = !out_v_q | out_ready;
    assign in_ready  = !s1_v_q | adv2;
    assign out_valid = out_v_q;
    assign out       = out_q;
    assign vxsat     = vxsat_q;

    // Next state: each stage loads when it may advance and holds under backpressure
    always_comb begin
        s1_v_d   = in_ready ? in_valid : s1_v_q;
        s1_res_d = in_ready & in_valid ? rw[sew + 2'(nr)] : s1_res_q;
        out_v_d  = adv2 ? s1_v_q : out_v_q;
        out_d    = adv2 & s1_v_q ? res2 : out_q;
        vxsat_d  = adv2 ? s1_v_q & sat2 : vxsat_q;
    end

    // Pipeline registers; reset drops every beat in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_q   <= 1'b0;
            s1_res_q <= '0;
            out_v_q  <= 1'b0;
            out_q    <= '0;
            vxsat_q  <= 1'b0;
        end else begin
            s1_v_q   <= s1_v_d;
            s1_res_q <= s1_res_d;
            out_v_q  <= out_v_d;
            out_q    <= out_d;
            vxsat_q  <= vxsat_d;
        end
    end
endmodule

// File: tb/tb_round_shift_pipe.sv
// tb_round_shift_pipe: vector table, directed pipeline sequences and random scoreboard for round_shift_pipe
module tb_round_shift_pipe;
`ifdef ROUND_SHIFT_NCLIP_EN
    localparam bit NCLIP = 1'b1;
`else
    localparam bit NCLIP = 1'b0;
`endif

    typedef struct {
        logic [1:0]   m;
        logic [1:0]   sw;
        logic         sg;
        logic         nr;
        logic [127:0] v;
        logic [127:0] d;
        logic [127:0] eo;
        logic         es;
    } vec_t;

    typedef struct {
        logic [127:0] o;
        logic         s;
    } res_t;

    logic         clk = 1'b0;
    logic         rst, in_valid, in_ready, is_signed, narrow, out_valid, out_ready, vxsat;
    logic [1:0]   vxrm, sew;
    logic [127:0] vs2, shamt, out;
    int           total = 0;
    int           bad = 0;
    res_t         sbq[$];

    round_shift_pipe #(.DATA_W(128)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .vxrm(vxrm), .sew(sew),
        .is_signed(is_signed), .narrow(narrow), .vs2(vs2), .shamt(shamt), .out_valid(out_valid),
        .out_ready(out_ready), .out(out), .vxsat(vxsat)
    );

    always #5 clk = ~clk;

    // Reference: floor-divide by 2^d, decide the increment from the remainder, then wrap or clip
    function automatic res_t model(input logic [1:0] m, input logic [1:0] sw, input logic sg, input logic nr_in,
                                   input logic [127:0] v, input logic [127:0] sh);
        res_t r;
        int eb, sb, d;
        logic signed [71:0] x, q, rem, half, res, lo, hi;
        logic [127:0] raw;
        logic inc;
        eb = 8 << sw;
        sb = (NCLIP && nr_in && sw != 2'b11) ? 2 * eb : eb;
        r.o = '0;
        r.s = 1'b0;
        for (int i = 0; i < 128 / sb; i++) begin
            raw = (v >> (i * sb)) & ((128'd1 << sb) - 128'd1);
            x = $signed(72'(raw));
            if (sg && raw[sb-1]) x = x - (72'sd1 <<< sb);
            d = int'(sh[i*sb +: 8]) % sb;
            q = x >>> d;
            rem = x - (q <<< d);
            half = (72'sd1 <<< d) >>> 1;
            case (m)
                2'b00: inc = d > 0 && rem >= half;
                2'b01: inc = d > 0 && (rem > half || (rem == half && q[0]));
                2'b10: inc = 1'b0;
                default: inc = rem != 0 && !q[0];
            endcase
            res = q + 72'(inc);
            if (sb != eb) begin
                lo = sg ? -(72'sd1 <<< (eb - 1)) : 72'sd0;
                hi = sg ? (72'sd1 <<< (eb - 1)) - 72'sd1 : (72'sd1 <<< eb) - 72'sd1;
                if (res > hi) begin
                    res = hi;
                    r.s = 1'b1;
                end else if (res < lo) begin
                    res = lo;
                    r.s = 1'b1;
                end
            end
            r.o = r.o | ((128'(res) & ((128'd1 << eb) - 128'd1)) << (i * eb));
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, a, e);
        end
    endtask

    task automatic drive(input logic [1:0] m, input logic [1:0] sw, input logic sg, input logic nr,
                         input logic [127:0] v, input logic [127:0] d);
        vxrm = m;
        sew = sw;
        is_signed = sg;
        narrow = nr;
        vs2 = v;
        shamt = d;
    endtask

    task automatic wait_out(input string nm);
        for (int k = 0; k < 8 && out_valid !== 1'b1; k++) @(negedge clk);
        chk({nm, " valid"}, 128'(out_valid), 128'd1);
    endtask

    task automatic run_vec(input vec_t t, input int n);
        @(negedge clk);
        drive(t.m, t.sw, t.sg, t.nr, t.v, t.d);
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        wait_out($sformatf("vec%0d", n));
        chk($sformatf("vec%0d out", n), out, t.eo);
        chk($sformatf("vec%0d vxsat", n), 128'(vxsat), 128'(t.es));
    endtask

    // Scoreboard: sample just before each rising edge, pop on delivery, push on acceptance
    initial forever begin
        res_t e;
        @(negedge clk);
        #4;
        if (rst) sbq.delete();
        else begin
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) chk("sb spurious beat", 128'(out_valid), 128'd0);
                else begin
                    e = sbq.pop_front();
                    chk("sb out", out, e.o);
                    chk("sb vxsat", 128'(vxsat), 128'(e.s));
                end
            end
            if (in_valid && in_ready) sbq.push_back(model(vxrm, sew, is_signed, narrow, vs2, shamt));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        vec_t tv[$];
        vec_t bp[3];
        res_t be[3];
        res_t e;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        drive(2'd0, 2'd0, 1'b0, 1'b0, '0, '0);
        repeat (3) @(negedge clk);
        chk("reset out_valid", 128'(out_valid), 128'd0);
        chk("reset out", out, 128'd0);
        chk("reset vxsat", 128'(vxsat), 128'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("reset in_ready", 128'(in_ready), 128'd1);

        tv.push_back('{2'd0, 2'd0, 1'b1, 1'b0, {16{8'h87}}, {16{8'd2}}, {16{8'hE2}}, 1'b0});
        tv.push_back('{2'd1, 2'd0, 1'b1, 1'b0, {16{8'h87}}, {16{8'd2}}, {16{8'hE2}}, 1'b0});
        tv.push_back('{2'd2, 2'd0, 1'b1, 1'b0, {16{8'h87}}, {16{8'd2}}, {16{8'hE1}}, 1'b0});
        tv.push_back('{2'd3, 2'd0, 1'b1, 1'b0, {16{8'h87}}, {16{8'd2}}, {16{8'hE1}}, 1'b0});
        tv.push_back('{2'd0, 2'd0, 1'b0, 1'b0, {16{8'h02}}, {16{8'd2}}, {16{8'h01}}, 1'b0});
        tv.push_back('{2'd1, 2'd0, 1'b0, 1'b0, {16{8'h02}}, {16{8'd2}}, {16{8'h00}}, 1'b0});
        tv.push_back('{2'd2, 2'd0, 1'b0, 1'b0, {16{8'h02}}, {16{8'd2}}, {16{8'h00}}, 1'b0});
        tv.push_back('{2'd3, 2'd0, 1'b0, 1'b0, {16{8'h02}}, {16{8'd2}}, {16{8'h01}}, 1'b0});
        tv.push_back('{2'd0, 2'd0, 1'b0, 1'b0, {16{8'hFF}}, {16{8'd0}}, {16{8'hFF}}, 1'b0});
        tv.push_back('{2'd1, 2'd0, 1'b0, 1'b0, {16{8'hFF}}, {16{8'd0}}, {16{8'hFF}}, 1'b0});
        tv.push_back('{2'd2, 2'd0, 1'b0, 1'b0, {16{8'hFF}}, {16{8'd0}}, {16{8'hFF}}, 1'b0});
        tv.push_back('{2'd3, 2'd0, 1'b0, 1'b0, {16{8'hFF}}, {16{8'd0}}, {16{8'hFF}}, 1'b0});
        tv.push_back('{2'd0, 2'd0, 1'b1, 1'b0, {16{8'h87}}, {16{8'h0A}}, {16{8'hE2}}, 1'b0});
        tv.push_back('{2'd1, 2'd2, 1'b0, 1'b0, {4{32'h18}}, {4{32'd4}}, {4{32'h2}}, 1'b0});
`ifdef ROUND_SHIFT_NCLIP_EN
        tv.push_back('{2'd0, 2'd0, 1'b1, 1'b1, {8{16'h7FFF}}, {8{16'd4}}, {64'd0, {8{8'h7F}}}, 1'b1});
`endif
        foreach (tv[i]) run_vec(tv[i], i);

        @(negedge clk);
        drive(2'd1, 2'd3, 1'b1, 1'b0, {64'h8000_0000_0000_0035, 64'h0123_4567_89AB_CDEF}, {64'd5, 64'd60});
        e = model(2'd1, 2'd3, 1'b1, 1'b0, vs2, shamt);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("lat64 cycle1 valid", 128'(out_valid), 128'd0);
        @(negedge clk);
        chk("lat64 cycle2 valid", 128'(out_valid), 128'd1);
        chk("lat64 out", out, e.o);

        for (int i = 0; i < 3; i++) begin
            bp[i] = '{2'(i), 2'(i), 1'(i), 1'b0, {$urandom, $urandom, $urandom, $urandom}, {4{$urandom}}, '0, 1'b0};
            be[i] = model(bp[i].m, bp[i].sw, bp[i].sg, bp[i].nr, bp[i].v, bp[i].d);
        end
        @(negedge clk);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(bp[i].m, bp[i].sw, bp[i].sg, bp[i].nr, bp[i].v, bp[i].d);
            in_valid = 1'b1;
            chk($sformatf("bp in_ready beat%0d", i), 128'(in_ready), i < 2 ? 128'd1 : 128'd0);
            if (i < 2) @(negedge clk);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp hold in_ready", 128'(in_ready), 128'd0);
            chk("bp hold valid", 128'(out_valid), 128'd1);
            chk("bp hold out", out, be[0].o);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("bp release valid%0d", i), 128'(out_valid), 128'd1);
            chk($sformatf("bp release out%0d", i), out, be[i].o);
            @(negedge clk);
            in_valid = 1'b0;
        end
        chk("bp drained", 128'(out_valid), 128'd0);

        out_ready = 1'b0;
        drive(2'd0, 2'd1, 1'b1, 1'b0, {4{$urandom}}, {8{16'd3}});
        in_valid = 1'b1;
        @(negedge clk);
        drive(2'd3, 2'd2, 1'b0, 1'b0, {4{$urandom}}, {4{32'd7}});
        @(negedge clk);
        in_valid = 1'b0;
        chk("rst mid in flight", 128'(out_valid), 128'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst mid valid", 128'(out_valid), 128'd0);
        chk("rst mid out", out, 128'd0);
        chk("rst mid vxsat", 128'(vxsat), 128'd0);
        rst = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("rst mid stale", 128'(out_valid), 128'd0);
        end

        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            in_valid = $urandom_range(0, 3) != 0;
            out_ready = $urandom_range(0, 3) != 0;
            drive(2'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
                  {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (10) @(negedge clk);
        chk("random drain empty", 128'(sbq.size()), 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
